// File: rtl/store_pkg.sv
// Shared encodings and payload types for the store alignment unit.
package store_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2
  } state_e;

  // One bus beat worth of lane-aligned data and strobes
  typedef struct packed {
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
  } beat_t;

endpackage

// File: rtl/store_align_if.sv
// Request and memory-bus handshake bundle for store_align.
interface store_align_if #(
  parameter int unsigned ADDR_W = 32
);
  import store_pkg::*;

  logic              REQ_VALID;
  logic              REQ_READY;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic [DATA_W-1:0] REQ_DATA;
  logic [1:0]        REQ_SIZE;

  logic              BUS_VALID;
  logic              BUS_READY;
  logic [ADDR_W-1:0] BUS_ADDR;
  logic [DATA_W-1:0] BUS_WDATA;
  logic [STRB_W-1:0] BUS_STRB;

  logic              ERR;
  logic              BUSY;

  // Store unit side
  modport slave (
    input  REQ_VALID, REQ_ADDR, REQ_DATA, REQ_SIZE, BUS_READY,
    output REQ_READY, BUS_VALID, BUS_ADDR, BUS_WDATA, BUS_STRB, ERR, BUSY
  );

  // Requester / memory side
  modport master (
    output REQ_VALID, REQ_ADDR, REQ_DATA, REQ_SIZE, BUS_READY,
    input  REQ_READY, BUS_VALID, BUS_ADDR, BUS_WDATA, BUS_STRB, ERR, BUSY
  );

endinterface

// File: rtl/store_lane_align.sv
// Combinational lane placement: shifts data/strobes into a 64-bit window
// spanning two words; beat 0 is the low word, beat 1 the spill-over word.
module store_lane_align
  import store_pkg::*;
(
  input  logic [1:0]        off,
  input  size_e             size,
  input  logic [DATA_W-1:0] data,
  input  logic              beat,
  output beat_t             lane,
  output logic              split
);

  logic [DATA_W-1:0]   dmask;
  logic [STRB_W-1:0]   smask;
  logic [2*DATA_W-1:0] wide;
  logic [2*STRB_W-1:0] strb_wide;

  // Narrow the register value to the access size
  always_comb begin
    dmask = '0;
    smask = '0;
    case (size)
      SZ_BYTE: begin
        dmask = DATA_W'(data[7:0]);
        smask = STRB_W'(4'b0001);
      end
      SZ_HALF: begin
        dmask = DATA_W'(data[15:0]);
        smask = STRB_W'(4'b0011);
      end
      SZ_WORD: begin
        dmask = data;
        smask = STRB_W'(4'b1111);
      end
      SZ_RSVD: begin
        dmask = '0;
        smask = '0;
      end
    endcase
  end

  // Shift into the two-word window and pick the requested beat
  always_comb begin
    wide      = (2*DATA_W)'(dmask) << {off, 3'b000};
    strb_wide = (2*STRB_W)'(smask) << off;
    split     = |strb_wide[2*STRB_W-1:STRB_W];
    if (beat) begin
      lane.wdata = wide[2*DATA_W-1:DATA_W];
      lane.strb  = strb_wide[2*STRB_W-1:STRB_W];
    end else begin
      lane.wdata = wide[DATA_W-1:0];
      lane.strb  = strb_wide[STRB_W-1:0];
    end
  end

endmodule

// File: rtl/store_align.sv
// Store-path alignment unit: turns a byte-addressed store into one or two
// word-aligned bus beats with byte strobes.
module store_align
  import store_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input logic          CLK,
  input logic          RST,
  store_align_if.slave bus
);

  state_e            state_q, state_nxt;
  logic [ADDR_W-1:0] base_q, base_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  size_e             size_q, size_nxt;
  logic [1:0]        off_q, off_nxt;
  logic              split_q, split_nxt;

  logic              valid_q, valid_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  beat_t             beat_q, beat_nxt;
  logic              err_q, err_nxt;
  logic              busy_q, busy_nxt;

  logic              accept, hs;
  size_e             req_size;
  logic [1:0]        la_off;
  size_e             la_size;
  logic [DATA_W-1:0] la_data;
  logic              la_beat;
  beat_t             la_lane;
  logic              la_split;

  assign req_size      = size_e'(bus.REQ_SIZE);
  assign bus.REQ_READY = (state_q == IDLE) & ~RST;
  assign accept        = bus.REQ_VALID & bus.REQ_READY;
  assign hs            = valid_q & bus.BUS_READY;

  // Live request feeds beat 1 at accept; latched request feeds beat 2
  always_comb begin
    if (state_q == IDLE) begin
      la_off  = bus.REQ_ADDR[1:0];
      la_size = req_size;
      la_data = bus.REQ_DATA;
      la_beat = 1'b0;
    end else begin
      la_off  = off_q;
      la_size = size_q;
      la_data = data_q;
      la_beat = 1'b1;
    end
  end

  store_lane_align u_lane (
    .off   (la_off),
    .size  (la_size),
    .data  (la_data),
    .beat  (la_beat),
    .lane  (la_lane),
    .split (la_split)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (accept && req_size != SZ_RSVD) state_nxt = BEAT1;
      BEAT1:   if (hs) state_nxt = split_q ? BEAT2 : IDLE;
      BEAT2:   if (hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the request latches and registered bus outputs
  always_comb begin
    base_nxt  = base_q;
    data_nxt  = data_q;
    size_nxt  = size_q;
    off_nxt   = off_q;
    split_nxt = split_q;
    valid_nxt = valid_q;
    addr_nxt  = addr_q;
    beat_nxt  = beat_q;
    err_nxt   = 1'b0;
    busy_nxt  = (state_nxt != IDLE);
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_size == SZ_RSVD) begin
            err_nxt = 1'b1;
          end else begin
            base_nxt  = {bus.REQ_ADDR[ADDR_W-1:2], 2'b00};
            data_nxt  = bus.REQ_DATA;
            size_nxt  = req_size;
            off_nxt   = bus.REQ_ADDR[1:0];
            split_nxt = la_split;
            valid_nxt = 1'b1;
            addr_nxt  = {bus.REQ_ADDR[ADDR_W-1:2], 2'b00};
            beat_nxt  = la_lane;
          end
        end
      end
      BEAT1: begin
        if (hs) begin
          if (split_q) begin
            addr_nxt = base_q + ADDR_W'(4);
            beat_nxt = la_lane;
          end else begin
            valid_nxt = 1'b0;
          end
        end
      end
      BEAT2: begin
        if (hs) valid_nxt = 1'b0;
      end
      default: valid_nxt = 1'b0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      base_q  <= '0;
      data_q  <= '0;
      size_q  <= SZ_BYTE;
      off_q   <= '0;
      split_q <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      base_q  <= base_nxt;
      data_q  <= data_nxt;
      size_q  <= size_nxt;
      off_q   <= off_nxt;
      split_q <= split_nxt;
      valid_q <= valid_nxt;
      addr_q  <= addr_nxt;
      beat_q  <= beat_nxt;
      err_q   <= err_nxt;
      busy_q  <= busy_nxt;
    end
  end

  assign bus.BUS_VALID = valid_q;
  assign bus.BUS_ADDR  = addr_q;
  assign bus.BUS_WDATA = beat_q.wdata;
  assign bus.BUS_STRB  = beat_q.strb;
  assign bus.ERR       = err_q;
  assign bus.BUSY      = busy_q;

endmodule

// File: tb/tb_store_align.sv
// Directed, table-driven bench for store_align.
module tb_store_align;

  logic CLK = 1'b0;
  logic RST;

  store_align_if #(.ADDR_W(32)) bus ();

  store_align #(.ADDR_W(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic        split;
    logic        err;
    logic [31:0] a1;
    logic [31:0] w1;
    logic [3:0]  s1;
    logic [31:0] a2;
    logic [31:0] w2;
    logic [3:0]  s2;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Issue one request with the bus always ready, check every beat
  task automatic run_vec(input vec_t v);
    chkb("req_ready_idle", bus.REQ_READY, 1'b1);
    bus.REQ_VALID = 1'b1;
    bus.REQ_ADDR  = v.addr;
    bus.REQ_DATA  = v.data;
    bus.REQ_SIZE  = v.size;
    bus.BUS_READY = 1'b1;
    step();
    bus.REQ_VALID = 1'b0;
    if (v.err) begin
      chkb("err_pulse", bus.ERR, 1'b1);
      chkb("err_no_valid", bus.BUS_VALID, 1'b0);
      chkb("err_not_busy", bus.BUSY, 1'b0);
      step();
      chkb("err_drop", bus.ERR, 1'b0);
      chkb("err_no_valid2", bus.BUS_VALID, 1'b0);
    end else begin
      chkb("b1_valid", bus.BUS_VALID, 1'b1);
      chk("b1_addr", bus.BUS_ADDR, v.a1);
      chk("b1_wdata", bus.BUS_WDATA, v.w1);
      chk("b1_strb", 32'(bus.BUS_STRB), 32'(v.s1));
      chkb("b1_busy", bus.BUSY, 1'b1);
      chkb("b1_ready_low", bus.REQ_READY, 1'b0);
      step();
      if (v.split) begin
        chkb("b2_valid", bus.BUS_VALID, 1'b1);
        chk("b2_addr", bus.BUS_ADDR, v.a2);
        chk("b2_wdata", bus.BUS_WDATA, v.w2);
        chk("b2_strb", 32'(bus.BUS_STRB), 32'(v.s2));
        step();
      end
      chkb("done_valid_low", bus.BUS_VALID, 1'b0);
      chkb("done_ready", bus.REQ_READY, 1'b1);
      chkb("done_busy_low", bus.BUSY, 1'b0);
    end
  endtask

  initial begin
    //             addr          data          sz    sp    er    a1            w1            s1     a2            w2            s2
    vecs[0]  = '{32'h00001003, 32'hAABBCCDD, 2'b00, 1'b0, 1'b0, 32'h00001000, 32'hDD000000, 4'h8, 32'h0,        32'h0,        4'h0};
    vecs[1]  = '{32'h00002002, 32'h1234ABCD, 2'b01, 1'b0, 1'b0, 32'h00002000, 32'hABCD0000, 4'hC, 32'h0,        32'h0,        4'h0};
    vecs[2]  = '{32'h00003001, 32'h11223344, 2'b10, 1'b1, 1'b0, 32'h00003000, 32'h22334400, 4'hE, 32'h00003004, 32'h00000011, 4'h1};
    vecs[3]  = '{32'hFFFFFFFF, 32'h0000BEEF, 2'b01, 1'b1, 1'b0, 32'hFFFFFFFC, 32'hEF000000, 4'h8, 32'h00000000, 32'h000000BE, 4'h1};
    vecs[4]  = '{32'h00000000, 32'h123456F0, 2'b00, 1'b0, 1'b0, 32'h00000000, 32'h000000F0, 4'h1, 32'h0,        32'h0,        4'h0};
    vecs[5]  = '{32'h00004000, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0, 32'h00004000, 32'hDEADBEEF, 4'hF, 32'h0,        32'h0,        4'h0};
    vecs[6]  = '{32'h00005002, 32'hAABBCCDD, 2'b10, 1'b1, 1'b0, 32'h00005000, 32'hCCDD0000, 4'hC, 32'h00005004, 32'h0000AABB, 4'h3};
    vecs[7]  = '{32'h00006003, 32'hAABBCCDD, 2'b10, 1'b1, 1'b0, 32'h00006000, 32'hDD000000, 4'h8, 32'h00006004, 32'h00AABBCC, 4'h7};
    vecs[8]  = '{32'h00007001, 32'hFFFF1234, 2'b01, 1'b0, 1'b0, 32'h00007000, 32'h00123400, 4'h6, 32'h0,        32'h0,        4'h0};
    vecs[9]  = '{32'h00008002, 32'h000000A5, 2'b00, 1'b0, 1'b0, 32'h00008000, 32'h00A50000, 4'h4, 32'h0,        32'h0,        4'h0};
    vecs[10] = '{32'h00009000, 32'h55555555, 2'b11, 1'b0, 1'b1, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        4'h0};

    RST           = 1'b1;
    bus.REQ_VALID = 1'b0;
    bus.REQ_ADDR  = '0;
    bus.REQ_DATA  = '0;
    bus.REQ_SIZE  = '0;
    bus.BUS_READY = 1'b0;
    step();
    step();

    // Reset state
    chkb("rst_ready", bus.REQ_READY, 1'b0);
    chkb("rst_valid", bus.BUS_VALID, 1'b0);
    chkb("rst_err", bus.ERR, 1'b0);
    chkb("rst_busy", bus.BUSY, 1'b0);
    chk("rst_addr", bus.BUS_ADDR, 32'h0);
    chk("rst_wdata", bus.BUS_WDATA, 32'h0);
    chk("rst_strb", 32'(bus.BUS_STRB), 32'h0);
    RST = 1'b0;
    #1;
    chkb("rst_release_ready", bus.REQ_READY, 1'b1);

    // Bus ready while nothing is valid must not start anything
    bus.BUS_READY = 1'b1;
    step();
    step();
    chkb("idle_ready_noeffect", bus.BUS_VALID, 1'b0);
    chkb("idle_busy", bus.BUSY, 1'b0);

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

    // Stall during beat 1 of a split word store; request pins wiggle meanwhile
    bus.REQ_VALID = 1'b1;
    bus.REQ_ADDR  = 32'h00003001;
    bus.REQ_DATA  = 32'h11223344;
    bus.REQ_SIZE  = 2'b10;
    bus.BUS_READY = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      chkb("stall_valid", bus.BUS_VALID, 1'b1);
      chk("stall_addr", bus.BUS_ADDR, 32'h00003000);
      chk("stall_wdata", bus.BUS_WDATA, 32'h22334400);
      chk("stall_strb", 32'(bus.BUS_STRB), 32'hE);
      chkb("stall_ready_low", bus.REQ_READY, 1'b0);
      chkb("stall_busy", bus.BUSY, 1'b1);
      bus.REQ_VALID = 1'b1;
      bus.REQ_ADDR  = 32'h0000BEE3 + 32'(c);
      bus.REQ_DATA  = $urandom;
      bus.REQ_SIZE  = 2'b01;
      if (c == 4) begin
        bus.REQ_VALID = 1'b0;
        bus.BUS_READY = 1'b1;
      end
      step();
    end
    chkb("stall_b2_valid", bus.BUS_VALID, 1'b1);
    chk("stall_b2_addr", bus.BUS_ADDR, 32'h00003004);
    chk("stall_b2_wdata", bus.BUS_WDATA, 32'h00000011);
    chk("stall_b2_strb", 32'(bus.BUS_STRB), 32'h1);
    step();
    chkb("stall_done_valid", bus.BUS_VALID, 1'b0);
    chkb("stall_done_ready", bus.REQ_READY, 1'b1);

    // Reset while beat 2 is stalled
    bus.REQ_VALID = 1'b1;
    bus.REQ_ADDR  = 32'h00005002;
    bus.REQ_DATA  = 32'hAABBCCDD;
    bus.REQ_SIZE  = 2'b10;
    bus.BUS_READY = 1'b1;
    step();
    bus.REQ_VALID = 1'b0;
    chk("rs_b1_strb", 32'(bus.BUS_STRB), 32'hC);
    step();
    bus.BUS_READY = 1'b0;
    chkb("rs_b2_valid", bus.BUS_VALID, 1'b1);
    chk("rs_b2_addr", bus.BUS_ADDR, 32'h00005004);
    step();
    chkb("rs_b2_held", bus.BUS_VALID, 1'b1);
    chk("rs_b2_wdata", bus.BUS_WDATA, 32'h0000AABB);
    chk("rs_b2_strb", 32'(bus.BUS_STRB), 32'h3);
    RST = 1'b1;
    step();
    chkb("rs_valid_dropped", bus.BUS_VALID, 1'b0);
    chkb("rs_ready_in_rst", bus.REQ_READY, 1'b0);
    chkb("rs_busy_low", bus.BUSY, 1'b0);
    RST = 1'b0;
    #1;
    chkb("rs_ready_after", bus.REQ_READY, 1'b1);
    step();
    run_vec(vecs[2]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
